posit_noncomp: RTL

- Non-computational posit operation unit for the posit FPU: MIN, MAX, EQ, LT, LE and CLASS on two posit operands.
- Sits directly downstream of posit_classifier. It instantiates posit_classifier with NumOperands = 2 and consumes its posit_pkg::posit_info_t outputs.
- Results travel through an elastic valid/ready pipeline toward the FPU result arbiter.

---
 rtl/posit_noncomp.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/posit_noncomp.sv
// Non-computational posit unit (MIN/MAX/EQ/LT/LE/CLASS) with an elastic output pipeline.
// Optional macro POSIT_NONCOMP_NAR_FLAG_EN adds a pipelined nar_o flag output.

package posit_pkg;
  typedef enum logic [1:0] {
    POSIT8  = 2'd0,
    POSIT16 = 2'd1,
    POSIT32 = 2'd2
  } posit_format_e;

  typedef struct packed {
    logic is_neg;
    logic is_pos;
    logic is_NaR;
    logic is_zero;
  } posit_info_t;

  function automatic int unsigned posit_width(posit_format_e fmt);
    case (fmt)
      POSIT16: return 16;
      POSIT32: return 32;
      default: return 8;
    endcase
  endfunction
endpackage

module posit_classifier #(
  parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
  parameter int unsigned NumOperands = 1,
  localparam int unsigned WIDTH = posit_pkg::posit_width(pFormat)
) (
  input  logic [NumOperands-1:0][WIDTH-1:0]      operands_i,
  output posit_pkg::posit_info_t [NumOperands-1:0] info_o
);
  localparam logic [WIDTH-1:0] NarPattern = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    info_o = '0;
    for (int i = 0; i < NumOperands; i++) begin
      info_o[i].is_zero = (operands_i[i] == '0);
      info_o[i].is_NaR  = (operands_i[i] == NarPattern);
      info_o[i].is_neg  = operands_i[i][WIDTH-1] && (operands_i[i] != NarPattern);
      info_o[i].is_pos  = !operands_i[i][WIDTH-1] && (operands_i[i] != '0);
    end
  end
endmodule

module posit_noncomp #(
  parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth = 4,
  localparam int unsigned WIDTH = posit_pkg::posit_width(pFormat)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0][WIDTH-1:0]    operands_i,
  input  logic [2:0]               op_i,
  input  logic [TagWidth-1:0]      tag_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         result_o,
  output logic [TagWidth-1:0]      tag_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
  ,output logic                    nar_o
`endif
);
  localparam logic [WIDTH-1:0] NarPattern = {1'b1, {(WIDTH-1){1'b0}}};

  posit_pkg::posit_info_t [1:0] info;
  logic signed [WIDTH-1:0] opA, opB;
  logic                    anyNar, aLtB, bLtA;
  logic [WIDTH-1:0]        opResult;
  logic                    unusedInfoB;

  posit_classifier #(
    .pFormat    (pFormat),
    .NumOperands(2)
  ) u_classifier (
    .operands_i(operands_i),
    .info_o    (info)
  );

  assign opA         = operands_i[0];
  assign opB         = operands_i[1];
  assign anyNar      = info[0].is_NaR || info[1].is_NaR;
  assign aLtB        = opA < opB;
  assign bLtA        = opB < opA;
  assign unusedInfoB = ^{info[1].is_neg, info[1].is_pos, info[1].is_zero};

  // NaR is the most negative two's-complement pattern, so signed compares already order it first
  always_comb begin
    opResult = '0;
    case (op_i)
      3'd0: opResult = anyNar ? NarPattern : (bLtA ? operands_i[1] : operands_i[0]);
      3'd1: opResult = anyNar ? NarPattern : (aLtB ? operands_i[1] : operands_i[0]);
      3'd2: opResult[0] = (operands_i[0] == operands_i[1]);
      3'd3: opResult[0] = aLtB;
      3'd4: opResult[0] = !bLtA;
      3'd5: opResult[3:0] = info[0];
      default: opResult = '0;
    endcase
  end

`ifdef POSIT_NONCOMP_NAR_FLAG_EN
  logic opNar;
  assign opNar = (op_i == 3'd5) ? info[0].is_NaR : anyNar;
`endif

  if (NumPipeRegs > 0) begin : gen_pipe
    logic [NumPipeRegs-1:0]               valid_q, valid_d, stageReady;
    logic [NumPipeRegs-1:0][WIDTH-1:0]    result_q, result_d;
    logic [NumPipeRegs-1:0][TagWidth-1:0] tag_q, tag_d;
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
    logic [NumPipeRegs-1:0]               nar_q, nar_d;
`endif

    // A stage can load iff it or some stage downstream of it has room to shift
    for (genvar g = 0; g < NumPipeRegs; g++) begin : gen_ready
      assign stageReady[g] = out_ready_i || !(&valid_q[NumPipeRegs-1:g]);
    end

    always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      tag_d    = tag_q;
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
      nar_d    = nar_q;
`endif
      if (stageReady[0]) begin
        valid_d[0]  = in_valid_i;
        result_d[0] = opResult;
        tag_d[0]    = tag_i;
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
        nar_d[0]    = opNar;
`endif
      end
      for (int i = 1; i < NumPipeRegs; i++) begin
        if (stageReady[i]) begin
          valid_d[i]  = valid_q[i-1];
          result_d[i] = result_q[i-1];
          tag_d[i]    = tag_q[i-1];
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
          nar_d[i]    = nar_q[i-1];
`endif
        end
      end
      if (flush_i) begin
        valid_d = '0;
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
        nar_d   = '0;
`endif
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q  <= '0;
        result_q <= '0;
        tag_q    <= '0;
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
        nar_q    <= '0;
`endif
      end else begin
        valid_q  <= valid_d;
        result_q <= result_d;
        tag_q    <= tag_d;
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
        nar_q    <= nar_d;
`endif
      end
    end

    assign in_ready_o  = stageReady[0];
    assign out_valid_o = valid_q[NumPipeRegs-1];
    assign result_o    = result_q[NumPipeRegs-1];
    assign tag_o       = tag_q[NumPipeRegs-1];
    assign busy_o      = |valid_q;
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
    assign nar_o       = nar_q[NumPipeRegs-1];
`endif
  end else begin : gen_comb
    logic unusedPipe;
    assign unusedPipe  = ^{clk_i, rst_i, flush_i};
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign result_o    = opResult;
    assign tag_o       = tag_i;
    assign busy_o      = 1'b0;
`ifdef POSIT_NONCOMP_NAR_FLAG_EN
    assign nar_o       = opNar;
`endif
  end
endmodule
